// File: rtl/sd_1011_tx.sv
`default_nettype none
// ============================================================================
//  Module      : sd_1011_tx
//  Description : Serial frame transmitter for the 1011 sequence-detector link.
//                Each frame is the 1011 sync header, then the W-bit payload
//                MSB-first with zero-stuffing so 1011 never recurs after the
//                header, then one guard 0.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous active-high reset
//                start  - frame request, sampled only while idle
//                din    - W-bit payload, latched on the accepted start
//                PO     - serial line (registered)
//                busy   - frame in progress
//                done   - one-cycle pulse during the guard bit
//                stuff  - PO carries a stuffed 0
//                sync   - PO carries a header bit
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_1011_tx #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] din,
    output logic         PO,
    output logic         busy,
    output logic         done,
    output logic         stuff,
    output logic         sync
);

    localparam int c_CW = $clog2(W + 1);
    localparam logic [c_CW-1:0] c_W_CNT = c_CW'(W);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SYNC  = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_STUFF = 3'd3;
    localparam logic [2:0] c_GUARD = 3'd4;

    // The state register names the symbol currently on PO; every output is
    // computed from the next state and registered alongside it.
    logic [2:0]      r_state, w_state_nxt;
    logic [1:0]      r_idx,   w_idx_nxt;    // header bit index on PO
    logic [c_CW-1:0] r_cnt,   w_cnt_nxt;    // payload bits already emitted
    logic [W-1:0]    r_sh,    w_sh_nxt;     // payload, MSB is next to send
    logic [2:0]      r_h,     w_h_nxt;      // last three PO bits of frame
    logic            r_po,    w_po_nxt;
    logic            r_busy,  w_busy_nxt;
    logic            r_done,  w_done_nxt;
    logic            r_stuff, w_stuff_nxt;
    logic            r_sync,  w_sync_nxt;

    // ------------------------------------------------------------------
    // State register (outputs registered together with the state)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_h     <= 3'b000;
            r_po    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_stuff <= 1'b0;
            r_sync  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sh    <= w_sh_nxt;
            r_h     <= w_h_nxt;
            r_po    <= w_po_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_stuff <= w_stuff_nxt;
            r_sync  <= w_sync_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_sh_nxt    = r_sh;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_SYNC;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                    w_sh_nxt    = din;
                end
            end
            c_SYNC: begin
                // History after the header is always 011, so the first
                // payload bit is never preceded by a stuff.
                if (r_idx == 2'd3) begin
                    w_state_nxt = c_DATA;
                end else begin
                    w_idx_nxt = r_idx + 2'd1;
                end
            end
            c_DATA: begin
                // The guard check comes first: no stuff after the last bit.
                if (r_cnt == c_W_CNT) begin
                    w_state_nxt = c_GUARD;
                end else if (r_h == 3'b101) begin
                    w_state_nxt = c_STUFF;
                end else begin
                    w_state_nxt = c_DATA;
                end
            end
            c_STUFF: w_state_nxt = c_DATA;
            c_GUARD: w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase

        // Every entry into DATA consumes one payload bit.
        if (w_state_nxt == c_DATA) begin
            w_sh_nxt  = r_sh << 1;
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output logic (values for the next PO symbol)
    // ------------------------------------------------------------------
    always_comb begin
        w_po_nxt    = 1'b0;
        w_sync_nxt  = 1'b0;
        w_stuff_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = (w_state_nxt != c_IDLE);
        case (w_state_nxt)
            c_SYNC: begin
                w_sync_nxt = 1'b1;
                case (w_idx_nxt)
                    2'd0:    w_po_nxt = 1'b1;
                    2'd1:    w_po_nxt = 1'b0;
                    default: w_po_nxt = 1'b1;
                endcase
            end
            c_DATA:  w_po_nxt    = r_sh[W-1];
            c_STUFF: w_stuff_nxt = 1'b1;
            c_GUARD: w_done_nxt  = 1'b1;
            default: w_po_nxt    = 1'b0;
        endcase
        // Leaving IDLE starts a fresh history for the new frame.
        if (r_state == c_IDLE) begin
            w_h_nxt = {2'b00, w_po_nxt};
        end else begin
            w_h_nxt = {r_h[1:0], w_po_nxt};
        end
    end

    assign PO    = r_po;
    assign busy  = r_busy;
    assign done  = r_done;
    assign stuff = r_stuff;
    assign sync  = r_sync;

endmodule
`default_nettype wire

// File: tb/tb_sd_1011_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_1011_tx
//  Description : Self-checking bench for sd_1011_tx. A frame-level model
//                builds the expected per-cycle {PO,busy,sync,stuff,done}
//                sequence from the framing rules; directed and random
//                payloads are compared cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_1011_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] din;
    logic         PO, busy, done, stuff, sync;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] exp_q[$];   // {PO, busy, sync, stuff, done}

    sd_1011_tx #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .din   (din),
        .PO    (PO),
        .busy  (busy),
        .done  (done),
        .stuff (stuff),
        .sync  (sync)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {PO, busy, sync, stuff, done};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Frame model: header, payload with a 0 inserted whenever the last
    // three line bits are 101 before a payload bit, then the guard 0.
    task automatic build_model(input logic [W-1:0] d);
        int hdr[4];
        int h;
        logic b;
        hdr = '{1, 0, 1, 1};
        exp_q.delete();
        h = 0;
        for (int i = 0; i < 4; i++) begin
            b = (hdr[i] == 1);
            exp_q.push_back({b, 1'b1, 1'b1, 1'b0, 1'b0});
            h = ((h << 1) | int'(b)) & 7;
        end
        for (int i = W - 1; i >= 0; i--) begin
            if (h == 5) begin
                exp_q.push_back(5'b01010);
                h = (h << 1) & 7;
            end
            b = d[i];
            exp_q.push_back({b, 1'b1, 1'b0, 1'b0, 1'b0});
            h = ((h << 1) | int'(b)) & 7;
        end
        exp_q.push_back(5'b01001);
    endtask

    // Called in an IDLE cycle at #1 after the edge; returns in the cycle
    // after the guard bit. keep leaves start asserted throughout.
    task automatic drive_frame(input logic [W-1:0] d, input bit keep,
                               output int busy_cnt, output int stuff_cnt);
        logic [3:0] win;
        int hits, pos;
        n_cmp++;
        if (obs() !== 5'b00000) begin
            n_err++;
            $display("FAIL idle_before_start din=%h: got %b want 00000", d, obs());
        end
        start = 1'b1;
        din   = d;
        build_model(d);
        next_cycle();
        if (!keep) start = 1'b0;
        din = W'($urandom);
        win = 4'b0000;
        hits = 0;
        pos = -1;
        busy_cnt = 0;
        stuff_cnt = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs() !== exp_q[i]) begin
                n_err++;
                $display("FAIL frame din=%h cycle %0d: got %b want %b", d, i + 1, obs(), exp_q[i]);
            end
            if (busy === 1'b1) busy_cnt++;
            if (stuff === 1'b1) stuff_cnt++;
            win = {win[2:0], PO};
            if (i >= 3 && win == 4'b1011) begin
                hits++;
                if (hits == 1) pos = i;
            end
            next_cycle();
        end
        n_cmp++;
        if (hits != 1 || pos != 3) begin
            n_err++;
            $display("FAIL sync_unique din=%h: got %0d hits first at %0d want 1 at 3", d, hits, pos);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        din   = '0;
        repeat (3) next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (obs() !== 5'b00000) begin
                n_err++;
                $display("FAIL reset_idle cycle %0d: got %b want 00000", i, obs());
            end
            next_cycle();
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] pats[4];
        int want_len[4];
        int want_stf[4];
        int bc, sc;
        pats     = '{8'hFF, 8'hA5, 8'h55, 8'h00};
        want_len = '{13, 14, 15, 13};
        want_stf = '{0, 1, 2, 0};
        for (int p = 0; p < 4; p++) begin
            drive_frame(pats[p], 1'b0, bc, sc);
            n_cmp++;
            if (bc != want_len[p] || sc != want_stf[p]) begin
                n_err++;
                $display("FAIL directed din=%h: busy %0d stuff %0d want %0d/%0d",
                         pats[p], bc, sc, want_len[p], want_stf[p]);
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        int bc, sc;
        for (int n = 0; n < 25; n++) begin
            drive_frame(W'($urandom), 1'b0, bc, sc);
            repeat ($urandom_range(0, 3)) begin
                start = 1'b0;
                din   = W'($urandom);
                n_cmp++;
                if (obs() !== 5'b00000) begin
                    n_err++;
                    $display("FAIL random_gap: got %b want 00000", obs());
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_back_to_back();
        int bc, sc;
        // start stays high: guard cycle must not accept, the next IDLE must.
        for (int n = 0; n < 3; n++) begin
            drive_frame(8'h00, 1'b1, bc, sc);
            n_cmp++;
            if (bc != 13) begin
                n_err++;
                $display("FAIL back_to_back frame %0d: busy %0d want 13", n, bc);
            end
        end
        start = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        int bc, sc;
        start = 1'b1;
        din   = W'($urandom);
        next_cycle();
        start = 1'b0;
        repeat (5) next_cycle();      // now in the 6th frame cycle
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_busy: got %b want 1", busy);
        end
        reset = 1'b1;
        start = 1'b1;
        next_cycle();
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (obs() !== 5'b00000) begin
                n_err++;
                $display("FAIL reset_mid_quiet cycle %0d: got %b want 00000", i, obs());
            end
            next_cycle();
        end
        drive_frame(W'($urandom), 1'b0, bc, sc);
        n_cmp++;
        if (obs() !== 5'b00000) begin
            n_err++;
            $display("FAIL after_frame_idle: got %b want 00000", obs());
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        din   = '0;
        #1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
